bram_sdp_pipe: RTL and testbench
================================

Name: bram_sdp_pipe

Overview:
- Parametrised simple-dual-port block RAM: one write port and one read port sharing a single clock.
- Adds per-byte write enables, a selectable read-during-write policy, 1- or 2-cycle read latency and a read-valid strobe.
- Serves as the storage primitive behind wishbone slave memories and FIFO/buffer blocks.
- Memory array infers vendor block RAM; only the pipeline/control registers are reset.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, read latency in cycles; 1 or 2 only (2 adds an output register).
- RDW_MODE, 0, same-address read/write collision policy: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data bypassed).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request this cycle.
- wr_be  in  NUM_BYTES  byte-lane write enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request this cycle.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data  out  DATA_WIDTH  read data; holds its last value between reads.
- rd_valid  out  1  one-cycle strobe per accepted read, aligned with rd_data.

Behaviour:
- Reset (async assert, sync release): rd_data=0, rd_valid=0, all pipeline valid bits and collision/bypass registers cleared. Array contents are not reset and are undefined after power-up.
- While rst is high, wr_en and rd_en are ignored: no array writes, no reads launched.
- Write: wr_en=1 in cycle c updates each lane whose wr_be bit is 1 at the end of cycle c. Lanes with wr_be=0 keep their old value. wr_en=1 with wr_be=0 is a legal no-op.
- Read: rd_en=1 in cycle c → rd_valid=1 and rd_data=word in cycle c+READ_LATENCY. Reads are fully pipelined: one read accepted per cycle, no stalls, no backpressure.
- rd_en=0: no rd_valid pulse READ_LATENCY cycles later; rd_data keeps its previous value.
- Collision: rd_en & wr_en & (rd_addr==wr_addr) in the same cycle c.
  - READ_FIRST: returned word is the pre-write contents.
  - WRITE_FIRST: returned word is byte-merged: lanes with wr_be=1 take wr_data, other lanes take the old array contents.
  - The merge is implemented with a registered bypass: registered wr_data, wr_be and a collision flag, muxed after the array read. It must not rely on array read-during-write semantics.
- Writes in cycles after c do not affect a read launched in cycle c, including with READ_LATENCY=2.
- Back-to-back writes to the same address: the last write wins.
- Addresses wrap naturally at 2**ADDR_WIDTH; there is no out-of-range case.
- Reset asserted mid-pipeline: in-flight reads are dropped, and no rd_valid appears after reset releases until a new rd_en.
- Illegal parameters (READ_LATENCY not 1 or 2, DATA_WIDTH % BYTE_WIDTH != 0) are caught by an elaboration-time check in simulation.

Decomposition:
- Shared package bram_pkg:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - Helper function computing NUM_BYTES.
- Sub-module bram_sdp_array:
  - Raw inferable memory with a byte-enable write port and a registered, unreset, read-first read port.
  - Carries the block-RAM synthesis attributes and no control logic.
- bram_sdp_pipe contains the valid pipeline, collision detect, bypass merge and optional output register.

Test Plan:
- Reset and idle: assert rst mid-clock → rd_data=0 and rd_valid=0 immediately. Release, idle 5 cycles → rd_valid stays 0.
- Full write/read: write addr 0x000=0x11223344 and 0x3FF=0xDEADBEEF with wr_be=0xF, then read both back-to-back → rd_valid high on two consecutive cycles with matching data, at latency 1 and at latency 2.
- Byte lanes: write 0xAABBCCDD to addr 5, then write 0x11223344 with wr_be=0x5 → read returns 0xAA22CC44.
- Collision: addr 7 holds 0x0; same cycle write 0xCAFEF00D (be=0xF) and read 7 → RDW_MODE=0 returns 0x00000000, RDW_MODE=1 returns 0xCAFEF00D. With be=0x3, mode 1 returns 0x0000F00D.
- Latency-2 isolation: read addr 9 (holds 0x1) in cycle c, write 0x2 to addr 9 in cycle c+1 → read returns 0x1; a later read returns 0x2.
- Reset mid-flight (READ_LATENCY=2): rd_en in cycle c, assert rst in cycle c+1 → no rd_valid after release; memory retains earlier written data.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants and helpers for the simple-dual-port block RAM family.
package bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Number of byte-enable lanes in a word.
    function automatic int calc_num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Raw inferable memory: byte-enable write port and registered read-first read port.
// No reset and no control logic, so synthesis maps it straight onto block RAM.
module bram_sdp_array
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    localparam int NUM_BYTES = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    (* ram_style = "block" *)
    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_word_q;

    // Byte-lane masked write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Registered read; non-blocking update returns pre-write contents on collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_word_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_word_q;

endmodule

// File: rtl/bram_sdp_pipe.sv
// Simple-dual-port RAM wrapper: read-valid pipeline, collision bypass for
// write-first mode, and an optional output register for 2-cycle latency.
module bram_sdp_pipe
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = RDW_READ_FIRST,
    localparam int NUM_BYTES   = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_sdp_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("bram_sdp_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic                  wr_go;
    logic                  rd_go;
    logic                  coll_d;
    logic [DATA_WIDTH-1:0] arr_word;
    logic [DATA_WIDTH-1:0] merged_word;

    logic                  v1_q;
    logic                  coll_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [NUM_BYTES-1:0]  byp_be_q;

    // Requests are ignored while reset is held.
    assign wr_go  = wr_en & ~rst;
    assign rd_go  = rd_en & ~rst;
    // Bypass is only armed in write-first mode; read-first gets the array's old data.
    assign coll_d = rd_go & wr_go & (rd_addr == wr_addr) & (RDW_MODE == RDW_WRITE_FIRST);

    bram_sdp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_go),
        .wr_be   (wr_be),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_go),
        .rd_addr (rd_addr),
        .rd_data (arr_word)
    );

    // First pipeline stage: read-valid plus captured collision write for the bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            coll_q     <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else begin
            v1_q   <= rd_go;
            coll_q <= coll_d;
            if (coll_d) begin
                byp_data_q <= wr_data;
                byp_be_q   <= wr_be;
            end
        end
    end

    // Byte-merge the captured write over the array word on a write-first collision.
    always_comb begin
        merged_word = arr_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (coll_q && byp_be_q[i]) begin
                merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        logic [DATA_WIDTH-1:0] last_q;

        // Remember the last delivered word so rd_data holds between reads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                last_q <= '0;
            end else if (v1_q) begin
                last_q <= merged_word;
            end
        end

        assign rd_data  = v1_q ? merged_word : last_q;
        assign rd_valid = v1_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] out_q;
        logic                  v2_q;

        // Output register stage; only loads on a valid read so data holds otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    out_q <= merged_word;
                end
            end
        end

        assign rd_data  = out_q;
        assign rd_valid = v2_q;
    end

endmodule

// File: tb/tb_bram_sdp_pipe.sv
// Bench for bram_sdp_pipe: four instances (latency 1/2 x read-first/write-first)
// share one stimulus stream; a reference memory feeds per-instance expectation queues.
module tb_bram_sdp_pipe;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_be = '0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [31:0] rd_data_w [4];
    logic        rd_valid_w [4];

    logic [31:0] model [0:1023];
    logic [31:0] last_w [4];
    exp_t        sb [4][$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bram_sdp_pipe #(
            .DATA_WIDTH   (32),
            .BYTE_WIDTH   (8),
            .ADDR_WIDTH   (10),
            .READ_LATENCY ((g / 2) + 1),
            .RDW_MODE     (g % 2)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en),
            .wr_be    (wr_be),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr),
            .rd_data  (rd_data_w[g]),
            .rd_valid (rd_valid_w[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; expectations are pushed before the model is updated.
    task automatic drive(input logic we, input logic [3:0] be, input logic [9:0] wa,
                         input logic [31:0] wd, input logic re, input logic [9:0] ra);
        logic [31:0] old;
        logic [31:0] wf;
        int          e;
        wr_en   = we;
        wr_be   = be;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (re) begin
            e   = cyc + 1;
            old = model[ra];
            wf  = old;
            if (we && wa == ra) begin
                for (int b = 0; b < 4; b++) if (be[b]) wf[b*8 +: 8] = wd[b*8 +: 8];
            end
            for (int i = 0; i < 4; i++) begin
                exp_t x;
                x.data = (i % 2 == 1) ? wf : old;
                x.due  = e + (i / 2);
                sb[i].push_back(x);
            end
        end
        if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) model[wa][b*8 +: 8] = wd[b*8 +: 8];
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        drive(1'b1, be, a, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [9:0] a);
        drive(1'b0, 4'h0, '0, '0, 1'b1, a);
    endtask

    // Output monitor on the falling edge: reset state, data/latency, hold and missed reads.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                chk($sformatf("rst_valid%0d", i), 32'(rd_valid_w[i]), 32'd0);
                chk($sformatf("rst_data%0d", i), rd_data_w[i], 32'd0);
                last_w[i] = '0;
            end else if (rd_valid_w[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    chk($sformatf("spurious_valid%0d", i), 32'(rd_valid_w[i]), 32'd0);
                end else begin
                    exp_t x;
                    x = sb[i].pop_front();
                    chk($sformatf("rd_data%0d", i), rd_data_w[i], x.data);
                    chk($sformatf("latency%0d", i), 32'(cyc), 32'(x.due));
                    last_w[i] = x.data;
                end
            end else begin
                chk($sformatf("valid_low%0d", i), 32'(rd_valid_w[i]), 32'd0);
                chk($sformatf("hold%0d", i), rd_data_w[i], last_w[i]);
                if (sb[i].size() != 0 && sb[i][0].due < cyc) begin
                    chk($sformatf("missed_read%0d", i), 32'd0, 32'd1);
                    void'(sb[i].pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) last_w[i] = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(5);

        // Full-word writes at both ends of the address space, back-to-back reads.
        wr(10'h000, 32'h11223344, 4'hF);
        wr(10'h3FF, 32'hDEADBEEF, 4'hF);
        rd(10'h000);
        rd(10'h3FF);
        idle(3);

        // Byte lanes.
        wr(10'd5, 32'hAABBCCDD, 4'hF);
        wr(10'd5, 32'h11223344, 4'h5);
        rd(10'd5);
        idle(3);

        // Collisions, full and partial byte enables.
        wr(10'd7, 32'h0, 4'hF);
        drive(1'b1, 4'hF, 10'd7, 32'hCAFEF00D, 1'b1, 10'd7);
        idle(3);
        wr(10'd7, 32'h0, 4'hF);
        drive(1'b1, 4'h3, 10'd7, 32'hCAFEF00D, 1'b1, 10'd7);
        rd(10'd7);
        idle(3);

        // A write one cycle after a read must not reach that read.
        wr(10'd9, 32'h1, 4'hF);
        rd(10'd9);
        wr(10'd9, 32'h2, 4'hF);
        idle(2);
        rd(10'd9);
        idle(3);

        // Last write wins; wr_be=0 is a no-op.
        wr(10'd11, 32'hA5A5A5A5, 4'hF);
        wr(10'd11, 32'h5A5A5A5A, 4'hF);
        wr(10'd11, 32'hFFFFFFFF, 4'h0);
        rd(10'd11);
        idle(3);

        // Reset while reads are in flight.
        rd(10'h000);
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            last_w[i] = '0;
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_rst_data%0d", i), rd_data_w[i], 32'd0);
            chk($sformatf("async_rst_valid%0d", i), 32'(rd_valid_w[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(5);
        rd(10'h000);
        rd(10'h3FF);
        rd(10'd5);
        idle(4);

        for (int i = 0; i < 4; i++) chk($sformatf("drained%0d", i), 32'(sb[i].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
